// File: rtl/player_input_hub_if.sv
`default_nettype none
// ============================================================================
// player_input_hub_if : raw pins and frame strobe in, player controls out
// Rev 1.0
// ============================================================================
interface player_input_hub_if #(
  parameter int N_PLAYERS = 2
);
  logic [5*N_PLAYERS-1:0] i_btn;
  logic                   i_frame_tick;
  logic [5*N_PLAYERS-1:0] o_led;
  logic [3*N_PLAYERS-1:0] o_dir;
  logic [N_PLAYERS-1:0]   o_fire;
  logic [N_PLAYERS-1:0]   o_start;

  modport master (output i_btn, i_frame_tick, input o_led, o_dir, o_fire, o_start);
  modport slave  (input i_btn, i_frame_tick, output o_led, o_dir, o_fire, o_start);
endinterface
`default_nettype wire

// File: rtl/player_input_hub.sv
`default_nettype none
// ============================================================================
// player_input_hub : per-button sync/debounce, per-player direction, fire, start
// Rev 1.0
// ============================================================================
module player_input_hub #(
  parameter int N_PLAYERS       = 2,
  parameter bit ACTIVE_LOW      = 1'b0,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 6250000,
  parameter int REPEAT_PERIOD   = 2500000,
  parameter int START_HOLD      = 25000000
) (
  input  logic              clk,
  input  logic              rst,
  player_input_hub_if.slave bus
);
  localparam int NB       = 5 * N_PLAYERS;
  localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_MAX = (REPEAT_DELAY > START_HOLD) ? REPEAT_DELAY : START_HOLD;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam int RP_W     = (REPEAT_PERIOD > 0) ? $clog2(REPEAT_PERIOD + 1) : 1;

  logic [NB-1:0] raw, sync1, sync2, deb, deb_d;

  assign raw        = ACTIVE_LOW ? ~bus.i_btn : bus.i_btn;
  assign bus.o_led  = deb;

  function automatic logic [1:0] first_set(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb_d <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bit
    logic [DB_W-1:0] cnt;
    logic            level;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt   <= '0;
        level <= 1'b0;
      end else if (sync2[b] == level) begin
        cnt <= '0;
      end else if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt   <= '0;
        level <= ~level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign deb[b] = level;
  end

  for (genvar p = 0; p < N_PLAYERS; p++) begin : g_player
    localparam int B = 5 * p;

    logic [3:0]        held, rise;
    logic              fire_held, fire_rise;
    logic              cur_valid, nxt_valid;
    logic [1:0]        cur_dir, nxt_dir;
    logic [HOLD_W-1:0] hold;
    logic [RP_W-1:0]   rep_cnt;
    logic              rep_active, start_done, pending, fire_q;
    logic [2:0]        dir_q;
    logic              first_rep, next_rep, fire_event, start_now;

    assign held      = deb[B +: 4];
    assign rise      = deb[B +: 4] & ~deb_d[B +: 4];
    assign fire_held = deb[B + 4];
    assign fire_rise = deb[B + 4] & ~deb_d[B + 4];

    assign first_rep  = fire_held && !rep_active && (REPEAT_PERIOD != 0)
                        && (hold == HOLD_W'(REPEAT_DELAY));
    assign next_rep   = fire_held && rep_active && (rep_cnt == RP_W'(REPEAT_PERIOD - 1));
    assign fire_event = fire_rise | first_rep | next_rep;
    assign start_now  = fire_held && !start_done && (hold == HOLD_W'(START_HOLD));

    // Newest press wins; losing the current one falls back by fixed priority.
    always_comb begin
      nxt_valid = cur_valid;
      nxt_dir   = cur_dir;
      if (|rise) begin
        nxt_valid = 1'b1;
        nxt_dir   = first_set(rise);
      end else if (cur_valid && !held[cur_dir]) begin
        nxt_valid = |held;
        nxt_dir   = (|held) ? first_set(held) : 2'd0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cur_valid  <= 1'b0;
        cur_dir    <= 2'd0;
        hold       <= '0;
        rep_cnt    <= '0;
        rep_active <= 1'b0;
        start_done <= 1'b0;
        pending    <= 1'b0;
        fire_q     <= 1'b0;
        dir_q      <= 3'd0;
      end else begin
        cur_valid <= nxt_valid;
        cur_dir   <= nxt_dir;
        if (!fire_held) begin
          hold       <= '0;
          rep_cnt    <= '0;
          rep_active <= 1'b0;
          start_done <= 1'b0;
        end else begin
          if (hold != HOLD_W'(HOLD_MAX)) hold <= hold + 1'b1;
          if (first_rep || next_rep) begin
            rep_active <= 1'b1;
            rep_cnt    <= '0;
          end else if (rep_active) begin
            rep_cnt <= rep_cnt + 1'b1;
          end
          if (start_now) start_done <= 1'b1;
        end
        // An event landing on the tick cycle belongs to the frame being closed.
        if (bus.i_frame_tick) begin
          fire_q  <= pending | fire_event;
          pending <= 1'b0;
          dir_q   <= {cur_valid, cur_dir};
        end else begin
          fire_q  <= 1'b0;
          pending <= pending | fire_event;
        end
      end
    end

    assign bus.o_dir[3*p +: 3] = dir_q;
    assign bus.o_fire[p]       = fire_q;
    assign bus.o_start[p]      = start_now;
  end
endmodule
`default_nettype wire

// File: tb/tb_player_input_hub.sv
`default_nettype none
// ============================================================================
// tb_player_input_hub : directed + randomized checks against a behavioural model
// Rev 1.0
// ============================================================================
module tb_player_input_hub;
  localparam int NP = 2;
  localparam int NB = 5 * NP;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;
  localparam int SH = 50;
  localparam int OW = 10 * NP;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn;
  logic          tick;
  int            errors = 0;
  int            checks = 0;

  player_input_hub_if #(.N_PLAYERS(NP)) bus_a ();
  player_input_hub_if #(.N_PLAYERS(NP)) bus_b ();

  assign bus_a.i_btn        = btn;
  assign bus_a.i_frame_tick = tick;
  assign bus_b.i_btn        = ~btn;
  assign bus_b.i_frame_tick = tick;

  player_input_hub #(.N_PLAYERS(NP), .ACTIVE_LOW(1'b0), .DEBOUNCE_CYCLES(DB),
                     .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .START_HOLD(SH))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  player_input_hub #(.N_PLAYERS(NP), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(DB),
                     .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .START_HOLD(SH))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  always #5 clk = ~clk;

  // Reference model state: "pressed" view of the pins, identical for both DUTs.
  logic [NB-1:0]   hist [0:DB];
  logic [NB-1:0]   m_led, m_led_prev;
  int              age  [NP];
  int              pend [NP];
  bit              cur_v [NP];
  logic [1:0]      cur_d [NP];
  logic [3*NP-1:0] m_dir;
  logic [NP-1:0]   m_fire, m_start;

  function automatic logic [1:0] lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  function automatic logic [OW-1:0] obs_a();
    return {bus_a.o_led, bus_a.o_dir, bus_a.o_fire, bus_a.o_start};
  endfunction

  function automatic logic [OW-1:0] obs_b();
    return {bus_b.o_led, bus_b.o_dir, bus_b.o_fire, bus_b.o_start};
  endfunction

  function automatic logic [OW-1:0] exp_all();
    return {m_led, m_dir, m_fire, m_start};
  endfunction

  // Advance one clock, update the model from the inputs seen at that edge, park on negedge.
  task automatic step();
    logic [NB-1:0] led_next;
    logic [3:0]    rs, hd;
    bit            f, ev, all_diff;
    @(posedge clk);
    if (rst) begin
      for (int j = 0; j <= DB; j++) hist[j] = '0;
      m_led = '0; m_led_prev = '0; m_dir = '0; m_fire = '0; m_start = '0;
      for (int p = 0; p < NP; p++) begin
        age[p] = 0; pend[p] = 0; cur_v[p] = 1'b0; cur_d[p] = 2'd0;
      end
    end else begin
      for (int p = 0; p < NP; p++) begin
        f  = m_led[5*p+4];
        ev = f && (!m_led_prev[5*p+4] || (age[p] >= RD && ((age[p] - RD) % RP) == 0));
        m_fire[p] = tick && (pend[p] > 0 || ev);
        if (tick) begin
          pend[p] = 0;
          m_dir[3*p +: 3] = cur_v[p] ? {1'b1, cur_d[p]} : 3'b000;
        end else if (ev) begin
          pend[p]++;
        end
        rs = m_led[5*p +: 4] & ~m_led_prev[5*p +: 4];
        hd = m_led[5*p +: 4];
        if (rs != 4'd0) begin
          cur_v[p] = 1'b1;
          cur_d[p] = lowest(rs);
        end else if (cur_v[p] && !hd[cur_d[p]]) begin
          cur_v[p] = (hd != 4'd0);
          cur_d[p] = lowest(hd);
        end
        age[p] = f ? age[p] + 1 : 0;
      end
      led_next = m_led;
      for (int b = 0; b < NB; b++) begin
        all_diff = 1'b1;
        for (int j = 1; j <= DB; j++) if (hist[j][b] == m_led[b]) all_diff = 1'b0;
        if (all_diff) led_next[b] = ~m_led[b];
      end
      for (int j = DB; j > 0; j--) hist[j] = hist[j-1];
      hist[0]    = btn;
      m_led_prev = m_led;
      m_led      = led_next;
      for (int p = 0; p < NP; p++) m_start[p] = m_led[5*p+4] && (age[p] == SH);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; btn = '1; tick = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++; if (obs_a() !== '0) begin errors++; $display("FAIL reset_a got=%h want=0", obs_a()); end
    checks++; if (obs_b() !== '0) begin errors++; $display("FAIL reset_b got=%h want=0", obs_b()); end
    rst = 1'b0; btn = '0; tick = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (obs_a() !== exp_all()) begin errors++; $display("FAIL idle_a got=%h want=%h", obs_a(), exp_all()); end
      checks++; if (obs_b() !== exp_all()) begin errors++; $display("FAIL idle_b got=%h want=%h", obs_b(), exp_all()); end
    end
  endtask

  task automatic test_debounce();
    btn[0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++; if (obs_a() !== exp_all()) begin errors++; $display("FAIL deb_model_a got=%h want=%h", obs_a(), exp_all()); end
      if (i == 5) begin
        checks++; if (bus_a.o_led[0] !== 1'b0) begin errors++; $display("FAIL deb_early got=%b want=0", bus_a.o_led[0]); end
      end
      if (i == 6) begin
        checks++; if (bus_a.o_led[0] !== 1'b1) begin errors++; $display("FAIL deb_latency got=%b want=1", bus_a.o_led[0]); end
        checks++; if (bus_b.o_led[0] !== 1'b1) begin errors++; $display("FAIL deb_latency_b got=%b want=1", bus_b.o_led[0]); end
      end
    end
    btn[1] = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i == 3) btn[1] = 1'b0;
      step();
      checks++; if (bus_a.o_led[1] !== 1'b0) begin errors++; $display("FAIL glitch got=%b want=0", bus_a.o_led[1]); end
      checks++; if (obs_b() !== exp_all()) begin errors++; $display("FAIL glitch_model_b got=%h want=%h", obs_b(), exp_all()); end
    end
    btn[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (obs_a() !== exp_all()) begin errors++; $display("FAIL deb_rel_a got=%h want=%h", obs_a(), exp_all()); end
    end
  endtask

  task automatic test_direction();
    logic [3:0] pins [3];
    logic [2:0] want [3];
    pins = '{4'b0100, 4'b1100, 4'b0100};
    want = '{3'b110, 3'b111, 3'b110};
    for (int ph = 0; ph < 3; ph++) begin
      btn[3:0] = pins[ph];
      for (int i = 0; i < 8; i++) begin
        step();
        checks++; if (obs_a() !== exp_all()) begin errors++; $display("FAIL dir_model_a got=%h want=%h", obs_a(), exp_all()); end
      end
      tick = 1'b1; step(); tick = 1'b0;
      checks++; if (bus_a.o_dir[2:0] !== want[ph]) begin errors++; $display("FAIL dir_phase%0d got=%b want=%b", ph, bus_a.o_dir[2:0], want[ph]); end
      checks++; if (bus_b.o_dir[2:0] !== want[ph]) begin errors++; $display("FAIL dir_phase%0d_b got=%b want=%b", ph, bus_b.o_dir[2:0], want[ph]); end
    end
    btn[3:0] = 4'b0000;
    for (int i = 0; i < 8; i++) step();
  endtask

  task automatic test_fire_pending();
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < 16; i++) begin
        btn[4] = (i < 8);
        step();
        checks++; if (obs_a() !== exp_all()) begin errors++; $display("FAIL pend_model_a got=%h want=%h", obs_a(), exp_all()); end
      end
    end
    tick = 1'b1; step(); tick = 1'b0;
    checks++; if (bus_a.o_fire !== 2'b01) begin errors++; $display("FAIL fire_pulse got=%b want=01", bus_a.o_fire); end
    step();
    checks++; if (bus_a.o_fire !== 2'b00) begin errors++; $display("FAIL fire_single got=%b want=00", bus_a.o_fire); end
    for (int i = 0; i < 10; i++) step();
    tick = 1'b1; step(); tick = 1'b0;
    checks++; if (bus_a.o_fire !== 2'b00) begin errors++; $display("FAIL fire_empty_frame got=%b want=00", bus_a.o_fire); end
  endtask

  task automatic test_autorepeat();
    int h;
    int ev_q[$];
    int st_q[$];
    int want_q[$];
    int starts2;
    tick = 1'b1;
    btn[4] = 1'b1;
    h = -1;
    for (int i = 0; i < 80; i++) begin
      step();
      checks++; if (obs_a() !== exp_all()) begin errors++; $display("FAIL rep_model_a got=%h want=%h", obs_a(), exp_all()); end
      if (h >= 0) h++;
      else if (bus_a.o_led[4]) h = 0;
      if (h > 0 && h <= 60 && bus_a.o_fire[0]) ev_q.push_back(h - 1);
      if (h >= 0 && bus_a.o_start[0]) st_q.push_back(h);
    end
    want_q.push_back(0);
    for (int k = RD; k < 60; k += RP) want_q.push_back(k);
    checks++; if (ev_q.size() != want_q.size()) begin errors++; $display("FAIL rep_count got=%0d want=%0d", ev_q.size(), want_q.size()); end
    for (int k = 0; k < ev_q.size() && k < want_q.size(); k++) begin
      checks++; if (ev_q[k] != want_q[k]) begin errors++; $display("FAIL rep_hold[%0d] got=%0d want=%0d", k, ev_q[k], want_q[k]); end
    end
    checks++; if (st_q.size() != 1) begin errors++; $display("FAIL start_count got=%0d want=1", st_q.size()); end
    else begin
      checks++; if (st_q[0] != SH) begin errors++; $display("FAIL start_hold got=%0d want=%0d", st_q[0], SH); end
    end
    btn[4] = 1'b0;
    for (int i = 0; i < 10; i++) step();
    btn[4] = 1'b1;
    starts2 = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      checks++; if (obs_b() !== exp_all()) begin errors++; $display("FAIL rearm_model_b got=%h want=%h", obs_b(), exp_all()); end
      if (bus_a.o_start[0]) starts2++;
    end
    checks++; if (starts2 != 1) begin errors++; $display("FAIL start_rearm got=%0d want=1", starts2); end
    btn[4] = 1'b0; tick = 1'b0;
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_isolation();
    tick = 1'b1; step(); tick = 1'b0;
    btn[0] = 1'b1; btn[9] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (obs_b() !== exp_all()) begin errors++; $display("FAIL iso_model_b got=%h want=%h", obs_b(), exp_all()); end
    end
    tick = 1'b1; step(); tick = 1'b0;
    checks++; if (bus_a.o_fire !== 2'b10) begin errors++; $display("FAIL iso_fire got=%b want=10", bus_a.o_fire); end
    checks++; if (bus_b.o_fire !== 2'b10) begin errors++; $display("FAIL iso_fire_b got=%b want=10", bus_b.o_fire); end
    checks++; if (bus_a.o_dir !== 6'b000_100) begin errors++; $display("FAIL iso_dir got=%b want=000100", bus_a.o_dir); end
    checks++; if (bus_b.o_led !== 10'b10_0000_0001) begin errors++; $display("FAIL iso_led_b got=%b want=1000000001", bus_b.o_led); end
    btn = '0;
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_reset_mid();
    btn[4] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++; if (obs_a() !== exp_all()) begin errors++; $display("FAIL mid_model_a got=%h want=%h", obs_a(), exp_all()); end
    end
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if (obs_a() !== '0) begin errors++; $display("FAIL mid_reset_a got=%h want=0", obs_a()); end
    checks++; if (obs_b() !== '0) begin errors++; $display("FAIL mid_reset_b got=%h want=0", obs_b()); end
    tick = 1'b1; step(); tick = 1'b0;
    checks++; if (bus_a.o_fire !== 2'b00) begin errors++; $display("FAIL mid_no_fire got=%b want=00", bus_a.o_fire); end
    btn[4] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++; if (obs_a() !== exp_all()) begin errors++; $display("FAIL mid_after_a got=%h want=%h", obs_a(), exp_all()); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < NB; b++)
        if ($urandom_range(((b % 5) == 4) ? 47 : 11, 0) == 0) btn[b] = ~btn[b];
      tick = ($urandom_range(15, 0) == 0);
      rst  = ($urandom_range(999, 0) == 0);
      step();
      checks++; if (obs_a() !== exp_all()) begin errors++; $display("FAIL rand_a cyc=%0d got=%h want=%h", i, obs_a(), exp_all()); end
      checks++; if (obs_b() !== exp_all()) begin errors++; $display("FAIL rand_b cyc=%0d got=%h want=%h", i, obs_b(), exp_all()); end
    end
    rst = 1'b0; tick = 1'b0;
  endtask

  initial begin
    rst = 1'b1; btn = '0; tick = 1'b0;
    test_reset();
    test_debounce();
    test_direction();
    test_fire_pending();
    test_autorepeat();
    test_isolation();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
